// File: rtl/rnd_arbiter.sv
// -----------------------------------------------------------------------------
// rnd_arbiter
//
// Shares one LFSR among NREQ requesters. Each cycle at most one requester is
// granted; the winner receives the LFSR word present on rnd_in and the LFSR
// is told to advance, so no two grants ever carry the same LFSR state.
// Requests that lose arbitration are remembered in a pending register until
// they are served. The round-robin pointer guarantees that any pending
// requester is served within NREQ arbitration cycles.
//
// A reseed request diverts the block for exactly one cycle (RESEED state) in
// which the LFSR seed is reloaded. Nothing is granted in that cycle, but
// incoming requests keep accumulating.
//
// Parameters
//   NREQ   number of requesters (2..16)
//   NBITS  random word width, equal to the attached LFSR width
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   req        per-requester request bits (pulses or levels)
//   reseed     single-cycle request to reload the LFSR seed
//   rnd_in     current LFSR output word
//   lfsr_next  advance strobe to the LFSR (combinational, winning cycles)
//   lfsr_load  seed-load strobe to the LFSR control (high in RESEED)
//   gnt        registered one-hot owner of rnd_out
//   rnd_out    registered random word for the granted requester
//   rnd_valid  registered, high exactly when gnt is nonzero
// -----------------------------------------------------------------------------
module rnd_arbiter #(
    parameter int NREQ  = 8,
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             reseed,
    input  logic [NBITS-1:0] rnd_in,
    output logic             lfsr_next,
    output logic             lfsr_load,
    output logic [NREQ-1:0]  gnt,
    output logic [NBITS-1:0] rnd_out,
    output logic             rnd_valid
);

    localparam int PTR_W = $clog2(NREQ);

    typedef enum logic {
        ST_RUN,
        ST_RESEED
    } state_t;

    state_t            state;
    logic [NREQ-1:0]   pend;
    logic [PTR_W-1:0]  ptr;

    logic [NREQ-1:0]   elig;
    logic [PTR_W-1:0]  lo_idx;
    logic [PTR_W-1:0]  hi_idx;
    logic              hi_found;
    logic [PTR_W-1:0]  win_idx;
    logic              win;
    logic [NREQ-1:0]   win_mask;

    // Round-robin selection. Scanning from the top down lets the last hit
    // overwrite earlier ones, so lo_idx ends as the lowest eligible index and
    // hi_idx as the lowest eligible index at or above ptr.
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        elig     = pend | req;
        lo_idx   = '0;
        hi_idx   = '0;
        hi_found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                lo_idx = PTR_W'(i);
                if (i >= int'(ptr)) begin
                    hi_idx   = PTR_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        win_idx  = hi_found ? hi_idx : lo_idx;
        win      = (state == ST_RUN) && (|elig);
        win_mask = win ? (NREQ'(1) << win_idx) : '0;
    end

    // req is live while rst is high, so the advance strobe is gated by rst to
    // keep the LFSR frozen during reset. lfsr_load decodes the state register,
    // which clears asynchronously, so it drops as soon as rst rises.
    assign lfsr_next = win && !rst;
    assign lfsr_load = (state == ST_RESEED);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            pend      <= '0;
            ptr       <= '0;
            gnt       <= '0;
            rnd_out   <= '0;
            rnd_valid <= 1'b0;
        end else begin
            // The winner's bit is cleared so a requester already pending and
            // still asserting req receives exactly one word. In RESEED
            // win_mask is zero, so requests just accumulate.
            pend      <= elig & ~win_mask;
            gnt       <= win_mask;
            rnd_valid <= win;
            if (win) begin
                rnd_out <= rnd_in;
                ptr     <= (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
            end

            // RESEED always lasts one cycle; reseed seen there is ignored.
            if (state == ST_RESEED) begin
                state <= ST_RUN;
            end else if (reseed) begin
                state <= ST_RESEED;
            end
        end
    end

endmodule

// File: tb/tb_rnd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rnd_arbiter
//
// Directed stimulus for rnd_arbiter with hand-computed expectations, plus a
// behavioural model (pending set, round-robin pointer, reseed flag) that is
// compared against the DUT on every falling edge. An attached 16-bit Galois
// LFSR drives rnd_in during the random-traffic phase, and an independent
// sequence tracker checks that granted words follow the LFSR sequence with
// no repeats or skips.
// -----------------------------------------------------------------------------
module tb_rnd_arbiter;

    localparam int          NREQ  = 8;
    localparam int          NBITS = 8;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NREQ-1:0]  req = '0;
    logic             reseed = 1'b0;
    logic [NBITS-1:0] rnd_drv = '0;
    logic [NBITS-1:0] rnd_in;
    logic             lfsr_next;
    logic             lfsr_load;
    logic [NREQ-1:0]  gnt;
    logic [NBITS-1:0] rnd_out;
    logic             rnd_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rnd_arbiter #(.NREQ(NREQ), .NBITS(NBITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .reseed    (reseed),
        .rnd_in    (rnd_in),
        .lfsr_next (lfsr_next),
        .lfsr_load (lfsr_load),
        .gnt       (gnt),
        .rnd_out   (rnd_out),
        .rnd_valid (rnd_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // ---------------- attached LFSR ----------------
    logic [15:0] lfsr = SEED;
    logic        use_lfsr = 1'b0;
    logic        s_next = 1'b0;
    logic        s_load = 1'b0;

    assign rnd_in = use_lfsr ? lfsr[7:0] : rnd_drv;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst)         lfsr <= SEED;
            else if (s_load) lfsr <= SEED;
            else if (s_next) lfsr <= lfsr_step(lfsr);
        end
    end

    // ---------------- behavioural model ----------------
    logic [NREQ-1:0]  m_pend  = '0;
    logic [NREQ-1:0]  m_gnt   = '0;
    logic [NBITS-1:0] m_rnd   = '0;
    logic             m_valid = 1'b0;
    logic             m_rs    = 1'b0;
    int               m_ptr   = 0;
    logic [NREQ-1:0]  m_elig;
    int               m_w;
    logic [15:0]      seq_lfsr = SEED;
    logic             seq_on = 1'b0;
    int               n_seq = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_pend = '0; m_gnt = '0; m_rnd = '0; m_valid = 1'b0;
                m_rs = 1'b0; m_ptr = 0; seq_lfsr = SEED;
            end else begin
                m_elig = m_pend | req;
                if (!m_rs && m_elig != '0) begin
                    // first eligible requester walking upward from ptr, modulo NREQ
                    m_w = -1;
                    for (int k = 0; k < NREQ; k++)
                        if (m_w < 0 && m_elig[(m_ptr + k) % NREQ]) m_w = (m_ptr + k) % NREQ;
                    m_gnt   = '0;
                    m_gnt[m_w] = 1'b1;
                    m_rnd   = rnd_in;
                    m_valid = 1'b1;
                    m_ptr   = (m_w + 1) % NREQ;
                    m_pend  = m_elig & ~m_gnt;
                end else begin
                    m_gnt   = '0;
                    m_valid = 1'b0;
                    m_pend  = m_elig;
                end
                if (m_rs) m_rs = 1'b0;
                else      m_rs = reseed;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            s_next = lfsr_next;
            s_load = lfsr_load;
            check("cyc_lfsr_next", 32'(lfsr_next), 32'(!rst && !m_rs && (|(m_pend | req))));
            check("cyc_lfsr_load", 32'(lfsr_load), 32'(!rst && m_rs));
            check("cyc_gnt",       32'(gnt),       32'(m_gnt));
            check("cyc_rnd_out",   32'(rnd_out),   32'(m_rnd));
            check("cyc_rnd_valid", 32'(rnd_valid), 32'(m_valid));
            if (seq_on && rnd_valid) begin
                check("seq_word", 32'(rnd_out), 32'(seq_lfsr[7:0]));
                seq_lfsr = lfsr_step(seq_lfsr);
                n_seq++;
            end
            if (lfsr_load) seq_lfsr = SEED;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [NREQ-1:0] r, input logic rs);
        @(posedge clk);
        #1;
        req    = r;
        reseed = rs;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; req = '0; reseed = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int g_cnt [NREQ];
    int nxt_cnt;

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_gnt",       32'(gnt),       32'h0);
        check("rst_rnd_valid", 32'(rnd_valid), 32'h0);
        check("rst_rnd_out",   32'(rnd_out),   32'h0);
        check("rst_lfsr_next", 32'(lfsr_next), 32'h0);
        check("rst_lfsr_load", 32'(lfsr_load), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Single request
        drive(8'h04, 1'b0); rnd_drv = 8'hA5;
        @(negedge clk);
        check("single_next", 32'(lfsr_next), 32'h1);
        drive(8'h00, 1'b0);
        @(negedge clk);
        check("single_gnt",   32'(gnt),       32'h04);
        check("single_rnd",   32'(rnd_out),   32'hA5);
        check("single_valid", 32'(rnd_valid), 32'h1);
        check("single_next0", 32'(lfsr_next), 32'h0);
        drive(8'h00, 1'b0);
        @(negedge clk);
        check("single_gnt0", 32'(gnt),     32'h00);
        check("single_hold", 32'(rnd_out), 32'hA5);

        // Contention and wrap
        do_reset();
        drive(8'h81, 1'b0); rnd_drv = 8'h11;
        @(negedge clk);
        check("wrap_next", 32'(lfsr_next), 32'h1);
        drive(8'h00, 1'b0); rnd_drv = 8'h22;
        @(negedge clk);
        check("wrap_gnt1",  32'(gnt),       32'h01);
        check("wrap_rnd1",  32'(rnd_out),   32'h11);
        check("wrap_next2", 32'(lfsr_next), 32'h1);
        drive(8'h00, 1'b0);
        @(negedge clk);
        check("wrap_gnt2",  32'(gnt),       32'h80);
        check("wrap_rnd2",  32'(rnd_out),   32'h22);
        check("wrap_idle",  32'(lfsr_next), 32'h0);
        drive(8'h81, 1'b0);
        drive(8'h00, 1'b0);
        @(negedge clk);
        check("wrap_ptr0", 32'(gnt), 32'h01);
        drive(8'h00, 1'b0);
        @(negedge clk);
        check("wrap_again", 32'(gnt), 32'h80);

        // Fairness: all requesting for 16 cycles
        do_reset();
        foreach (g_cnt[i]) g_cnt[i] = 0;
        nxt_cnt = 0;
        drive(8'hFF, 1'b0);
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if (k < 16 && lfsr_next) nxt_cnt++;
            if (k >= 1) begin
                check("fair_walk", 32'(gnt), 32'(8'h01 << ((k - 1) % 8)));
                for (int i = 0; i < NREQ; i++) if (gnt[i]) g_cnt[i]++;
            end
            if (k < 16) begin
                @(posedge clk);
                #1;
                if (k == 15) req = '0;
            end
        end
        check("fair_next_cnt", 32'(nxt_cnt), 32'd16);
        for (int i = 0; i < NREQ; i++) check("fair_twice", 32'(g_cnt[i]), 32'd2);
        repeat (10) drive(8'h00, 1'b0);

        // Reseed
        do_reset();
        drive(8'h00, 1'b1);
        @(negedge clk);
        check("rs_run_load", 32'(lfsr_load), 32'h0);
        drive(8'h10, 1'b0);
        @(negedge clk);
        check("rs_load",    32'(lfsr_load), 32'h1);
        check("rs_no_next", 32'(lfsr_next), 32'h0);
        drive(8'h00, 1'b0);
        @(negedge clk);
        check("rs_exit_load", 32'(lfsr_load), 32'h0);
        check("rs_no_gnt",    32'(gnt),       32'h00);
        check("rs_next",      32'(lfsr_next), 32'h1);
        drive(8'h00, 1'b0);
        @(negedge clk);
        check("rs_gnt", 32'(gnt), 32'h10);
        // reseed held into RESEED is ignored
        drive(8'h00, 1'b1);
        drive(8'h00, 1'b1);
        drive(8'h00, 1'b0);
        @(negedge clk);
        check("rs_no_extend", 32'(lfsr_load), 32'h0);

        // Async reset with pend = 0C
        do_reset();
        drive(8'h01, 1'b1); rnd_drv = 8'h5A;
        drive(8'h0C, 1'b0);
        @(negedge clk);
        check("ar_gnt",  32'(gnt),       32'h01);
        check("ar_load", 32'(lfsr_load), 32'h1);
        drive(8'h00, 1'b0);
        #1 check("ar_pend_next", 32'(lfsr_next), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("ar_next0",  32'(lfsr_next), 32'h0);
        check("ar_load0",  32'(lfsr_load), 32'h0);
        check("ar_gnt0",   32'(gnt),       32'h0);
        check("ar_valid0", 32'(rnd_valid), 32'h0);
        check("ar_rnd0",   32'(rnd_out),   32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) begin
            drive(8'h00, 1'b0);
            @(negedge clk);
            check("ar_quiet_gnt",  32'(gnt),       32'h0);
            check("ar_quiet_next", 32'(lfsr_next), 32'h0);
        end

        // Reset in the middle of RESEED
        drive(8'h00, 1'b1);
        drive(8'h00, 1'b0);
        #1 check("mid_rs_load", 32'(lfsr_load), 32'h1);
        #1 rst = 1'b1;
        #1 check("mid_rs_drop", 32'(lfsr_load), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        drive(8'h00, 1'b0);
        @(negedge clk);
        check("mid_rs_after", 32'(lfsr_load), 32'h0);

        // Random traffic against the attached LFSR
        do_reset();
        use_lfsr = 1'b1;
        seq_on   = 1'b1;
        for (int c = 0; c < 400; c++)
            drive(NREQ'($urandom & $urandom), (c % 60) == 30);
        repeat (12) drive(8'h00, 1'b0);
        @(negedge clk);
        check("seq_delivered", 32'(n_seq >= 100), 32'h1);
        seq_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rnd_arbiter.md
RND_ARBITER -- requirements
Module: rnd_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 8, meaning the number of requesters sharing one LFSR (legal range 2..16).
REQ-002 The block SHALL have parameter NBITS, default 8, meaning the random word width, equal to the attached LFSR's NBITS.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 Port req  input  NREQ  SHALL carry the per-requester random-word request pulses or levels, where bit i belongs to requester i.
REQ-006 Port reseed  input  1  SHALL be a single-cycle request to reload the LFSR seed.
REQ-007 Port rnd_in  input  NBITS  SHALL carry the current LFSR output word.
REQ-008 Port lfsr_next  output  1  SHALL be the advance strobe to the LFSR.
REQ-009 Port lfsr_load  output  1  SHALL be the seed-load strobe to the LFSR control logic.
REQ-010 Port gnt  output  NREQ  SHALL be a one-hot, registered indication of which requester owns rnd_out this cycle.
REQ-011 Port rnd_out  output  NBITS  SHALL be the registered random word delivered to the granted requester.
REQ-012 Port rnd_valid  output  1  SHALL be high exactly when gnt is nonzero.

Function
REQ-013 The block SHALL keep a pending register pend[NREQ-1:0]; eligible set elig = pend | req.
REQ-014 While the FSM is in RUN and elig is nonzero, the block SHALL select exactly one winner w by round-robin: lowest index >= ptr in elig, else lowest index in elig (wrap-around).
REQ-015 In a winning cycle the block SHALL assert lfsr_next combinationally and, at the next edge, register gnt = onehot(w), rnd_out = rnd_in, rnd_valid = 1, ptr = (w+1) mod NREQ.
REQ-016 Latency SHALL be exactly one cycle from req[i] rising with no contention to gnt[i]/rnd_valid high.
REQ-017 At each edge pend SHALL update to elig with the winner bit cleared; a requester asking while already pending SHALL still receive only one word.
REQ-018 With elig zero, the block SHALL hold lfsr_next low, drive gnt and rnd_valid to 0 at the next edge, leave rnd_out at its last value, and leave ptr unchanged.
REQ-019 Each LFSR value SHALL be delivered to at most one requester; no two grants SHALL carry the same LFSR state.
REQ-020 The FSM SHALL have states RUN and RESEED.
REQ-021 In RUN, reseed=1 SHALL move the FSM to RESEED at the next edge, and the current cycle SHALL still arbitrate normally.
REQ-022 In RESEED the block SHALL assert lfsr_load, hold lfsr_next low, grant nothing, keep accumulating req into pend, and return to RUN at the next edge.
REQ-023 reseed asserted while already in RESEED SHALL be ignored, with no extension of the state.
REQ-024 No starvation: any requester with pend set SHALL be granted within NREQ arbitration cycles.

Reset
REQ-025 While rst=1, the block SHALL force pend=0, ptr=0, FSM=RUN, gnt=0, rnd_valid=0, rnd_out=0, lfsr_next=0 and lfsr_load=0, asynchronously.
REQ-026 Requests present during reset SHALL be discarded; arbitration SHALL resume on the first edge after rst deasserts.
REQ-027 rst asserted mid-RESEED SHALL abort the reseed, and lfsr_load SHALL drop immediately.

Verification
REQ-028 Single request: req=8'h04 for one cycle, rnd_in=8'hA5 -> lfsr_next=1 that cycle; next cycle gnt=8'h04, rnd_out=8'hA5, rnd_valid=1; then gnt=0.
REQ-029 Contention and wrap: ptr=0, req=8'h81 held one cycle -> grants in order 8'h01 then 8'h80 on consecutive cycles, ptr ends at 0, and pend ends at 0.
REQ-030 Fairness: req=8'hFF held 16 cycles -> gnt walks 01,02,...,80,01,... with each requester granted exactly twice and lfsr_next high all 16 cycles.
REQ-031 Reseed: reseed pulse with req=8'h10 in the following cycle -> lfsr_load high for one cycle, no grant that cycle, and gnt=8'h10 one cycle after RESEED exits.
REQ-032 Async reset: rst asserted between edges while pend=8'h0C -> all outputs 0 immediately, and no grant after release without new req.
REQ-033 Model check: attached LFSR model with seed 16'hACE1 and random req traffic -> the sequence of rnd_out words SHALL equal the LFSR output sequence with no repeats or skips.
